cdb_arbiter: RTL and testbench

//  Shares one common data bus (CDB) among N result producers (ALU, LSB load path, branch unit).

---
 rtl/cdb_arbiter_pkg.sv | 31 +++
 rtl/cdb_src_fifo.sv | 46 ++++
 rtl/cdb_arbiter.sv | 122 ++++++++++++
 tb/tb_cdb_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants, payload type and helpers for the common data bus arbiter.
// Source index constants: CDB_ALU, CDB_LD, CDB_BR.
package cdb_arbiter_pkg;

    localparam int unsigned N_SRC  = 3;   // producers: ALU, LSB load, branch
    localparam int unsigned DEPTH  = 2;   // entries per source FIFO (power of 2, >= 2)
    localparam int unsigned ROB_W  = 4;   // ROB name width
    localparam int unsigned DATA_W = 32;  // result width

    localparam int unsigned SRC_W  = $clog2(N_SRC);
    localparam int unsigned SUM_W  = SRC_W + 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam int unsigned CDB_ALU = 0;
    localparam int unsigned CDB_LD  = 1;
    localparam int unsigned CDB_BR  = 2;

    // One broadcast payload: ROB name plus result.
    typedef struct packed {
        logic [ROB_W-1:0]  rob;
        logic [DATA_W-1:0] data;
    } cdb_entry_t;

    // Next source index, wrapping modulo N_SRC.
    function automatic logic [SRC_W-1:0] src_inc(input logic [SRC_W-1:0] s);
        if (s == SRC_W'(N_SRC - 1)) return '0;
        return s + SRC_W'(1);
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-producer FIFO of DEPTH cdb_entry_t entries.
// Ports: clk, rst (sync, active-high), flush (clears contents), push/din (write at tail),
//        pop (drop head), count_c/empty_c/full_c/head_c (combinational views of state).
// The caller guarantees push only when not full and pop only when not empty.
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  cdb_entry_t       din,
    input  logic             pop,
    output logic [CNT_W-1:0] count_c,
    output logic             empty_c,
    output logic             full_c,
    output cdb_entry_t       head_c
);

    cdb_entry_t       mem [DEPTH];
    logic [PTR_W:0]   wr_q;   // index plus wrap bit
    logic [PTR_W:0]   rd_q;

    // Pointer state; flush empties the FIFO just like reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + (PTR_W+1)'(1);
            if (pop)  rd_q <= rd_q + (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset: contents are only visible between rd and wr.
    always_ff @(posedge clk) begin
        if (push) mem[wr_q[PTR_W-1:0]] <= din;
    end

    assign count_c = CNT_W'(wr_q - rd_q);
    assign empty_c = (wr_q == rd_q);
    assign full_c  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                     (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign head_c  = mem[rd_q[PTR_W-1:0]];

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: N_SRC producers push {rob, data} into private FIFOs,
// one result per cycle is granted round-robin and broadcast on registered cdb_* outputs.
// Ports: clk, rst (sync, active-high), rdy (global enable, low freezes everything),
//        flush (discard all pending results), src_valid/src_ready/src_rob/src_data (producer side),
//        cdb_sgn/cdb_rob/cdb_data/cdb_src (registered broadcast).
// Build option: CDB_LOAD_PRIO_EN gives the LSB load source absolute priority; the
// remaining sources share round-robin and rr only advances on non-load grants.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic [N_SRC-1:0]          src_valid,
    output logic [N_SRC-1:0]          src_ready,
    input  logic [N_SRC*ROB_W-1:0]    src_rob,
    input  logic [N_SRC*DATA_W-1:0]   src_data,
    output logic                      cdb_sgn,
    output logic [ROB_W-1:0]          cdb_rob,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [SRC_W-1:0]          cdb_src
);

    cdb_entry_t       din_c   [N_SRC];
    cdb_entry_t       head_c  [N_SRC];
    logic [CNT_W-1:0] count_c [N_SRC];
    logic [N_SRC-1:0] empty_c;
    logic [N_SRC-1:0] full_c;
    logic [N_SRC-1:0] push_c;
    logic [N_SRC-1:0] pop_c;

    logic             grant_vld_c;
    logic [SRC_W-1:0] grant_idx_c;
    cdb_entry_t       grant_head_c;
    logic [SRC_W-1:0] rr_q;

    // Per-source FIFOs; ready depends only on registered occupancy, never on src_valid.
    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        assign src_ready[g] = rdy && !flush && (count_c[g] != CNT_W'(DEPTH));
        assign push_c[g]    = src_valid[g] && src_ready[g];
        assign pop_c[g]     = grant_vld_c && (grant_idx_c == SRC_W'(g)) && rdy && !flush;
        assign din_c[g]     = '{rob: src_rob[g*ROB_W +: ROB_W], data: src_data[g*DATA_W +: DATA_W]};

        cdb_src_fifo u_fifo (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .push    (push_c[g]),
            .din     (din_c[g]),
            .pop     (pop_c[g]),
            .count_c (count_c[g]),
            .empty_c (empty_c[g]),
            .full_c  (full_c[g]),
            .head_c  (head_c[g])
        );
    end

    // Pick the first non-empty FIFO scanning rr, rr+1, ... modulo N_SRC.
    always_comb begin
        logic [SUM_W-1:0] sum;
        logic [SRC_W-1:0] idx;
        logic             skip;
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        sum         = '0;
        idx         = '0;
        skip        = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            sum = {1'b0, rr_q} + SUM_W'(k);
            if (sum >= SUM_W'(N_SRC)) sum = sum - SUM_W'(N_SRC);
            idx = sum[SRC_W-1:0];
`ifdef CDB_LOAD_PRIO_EN
            skip = (idx == SRC_W'(CDB_LD));
`else
            skip = 1'b0;
`endif
            if (!grant_vld_c && !skip && !empty_c[idx]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = idx;
            end
        end
`ifdef CDB_LOAD_PRIO_EN
        // Load results bypass the rotation entirely.
        if (!empty_c[CDB_LD]) begin
            grant_vld_c = 1'b1;
            grant_idx_c = SRC_W'(CDB_LD);
        end
`endif
    end

    assign grant_head_c = head_c[grant_idx_c];

    // Broadcast registers and rr pointer; rst beats flush, flush beats rdy gating.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_sgn  <= 1'b0;
            cdb_rob  <= '0;
            cdb_data <= '0;
            cdb_src  <= '0;
            rr_q     <= '0;
        end else if (flush) begin
            cdb_sgn  <= 1'b0;
            rr_q     <= '0;
        end else if (rdy) begin
            if (grant_vld_c) begin
                cdb_sgn  <= 1'b1;
                cdb_rob  <= grant_head_c.rob;
                cdb_data <= grant_head_c.data;
                cdb_src  <= grant_idx_c;
`ifdef CDB_LOAD_PRIO_EN
                if (grant_idx_c != SRC_W'(CDB_LD)) rr_q <= src_inc(grant_idx_c);
`else
                rr_q <= src_inc(grant_idx_c);
`endif
            end else begin
                cdb_sgn <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the bus.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int unsigned ENT_W = ROB_W + DATA_W;

    logic                    clk;
    logic                    rst;
    logic                    rdy;
    logic                    flush;
    logic [N_SRC-1:0]        src_valid;
    logic [N_SRC-1:0]        src_ready;
    logic [N_SRC*ROB_W-1:0]  src_rob;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic                    cdb_sgn;
    logic [ROB_W-1:0]        cdb_rob;
    logic [DATA_W-1:0]       cdb_data;
    logic [SRC_W-1:0]        cdb_src;

    cdb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (flush),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_rob   (src_rob),
        .src_data  (src_data),
        .cdb_sgn   (cdb_sgn),
        .cdb_rob   (cdb_rob),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: one queue of pending {rob,data} per source plus the visible bus.
    logic [ENT_W-1:0]  mq [N_SRC][$];
    int                m_rr;
    logic              exp_sgn;
    logic [ROB_W-1:0]  exp_rob;
    logic [DATA_W-1:0] exp_data;
    logic [SRC_W-1:0]  exp_src;
    int                seen [$];   // sources observed on the bus

`ifdef CDB_LOAD_PRIO_EN
    localparam bit LOAD_PRIO = 1'b1;
`else
    localparam bit LOAD_PRIO = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        int idx;
        if (LOAD_PRIO && mq[CDB_LD].size() > 0) return CDB_LD;
        for (int k = 0; k < N_SRC; k++) begin
            idx = (m_rr + k) % N_SRC;
            if (LOAD_PRIO && idx == CDB_LD) continue;
            if (mq[idx].size() > 0) return idx;
        end
        return -1;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < N_SRC; i++) mq[i].delete();
    endtask

    task automatic offer(input int i, input logic [ROB_W-1:0] r, input logic [DATA_W-1:0] d);
        src_valid[i]                  = 1'b1;
        src_rob[i*ROB_W +: ROB_W]     = r;
        src_data[i*DATA_W +: DATA_W]  = d;
    endtask

    task automatic idle();
        src_valid = '0;
    endtask

    // One clock: check ready before the edge, advance the model, check the bus after it.
    task automatic cycle();
        logic [N_SRC-1:0] acc;
        logic             er;
        logic [ENT_W-1:0] e;
        int               g;
        #1;
        for (int i = 0; i < N_SRC; i++) begin
            er = rdy && !flush && (mq[i].size() < DEPTH);
            chk($sformatf("src_ready[%0d]", i), 64'(src_ready[i]), 64'(er));
            acc[i] = src_valid[i] && er;
        end
        @(posedge clk);
        if (rst) begin
            clear_model();
            m_rr = 0; exp_sgn = 1'b0; exp_rob = '0; exp_data = '0; exp_src = '0;
        end else if (flush) begin
            clear_model();
            m_rr = 0; exp_sgn = 1'b0;
        end else if (rdy) begin
            g = pick();
            if (g >= 0) begin
                e        = mq[g].pop_front();
                exp_sgn  = 1'b1;
                exp_rob  = e[ENT_W-1 -: ROB_W];
                exp_data = e[DATA_W-1:0];
                exp_src  = SRC_W'(g);
                if (!(LOAD_PRIO && g == CDB_LD)) m_rr = (g + 1) % N_SRC;
            end else begin
                exp_sgn = 1'b0;
            end
            for (int i = 0; i < N_SRC; i++)
                if (acc[i]) mq[i].push_back({src_rob[i*ROB_W +: ROB_W], src_data[i*DATA_W +: DATA_W]});
        end
        #1;
        chk("cdb_sgn",  64'(cdb_sgn),  64'(exp_sgn));
        chk("cdb_rob",  64'(cdb_rob),  64'(exp_rob));
        chk("cdb_data", 64'(cdb_data), 64'(exp_data));
        if (exp_sgn) chk("cdb_src", 64'(cdb_src), 64'(exp_src));
        if (cdb_sgn === 1'b1) seen.push_back(int'(cdb_src));
        @(negedge clk);
    endtask

    task automatic flush_cycle();
        idle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    initial begin
        int exp_t6 [4];
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        src_valid = '0; src_rob = '0; src_data = '0;
        clear_model();
        m_rr = 0; exp_sgn = 1'b0; exp_rob = '0; exp_data = '0; exp_src = '0;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
        chk("reset_sgn",  64'(cdb_sgn),   64'd0);
        chk("reset_data", 64'(cdb_data),  64'd0);
        chk("reset_rdy",  64'(src_ready), 64'd7);

        // Single ALU result appears two edges after the push.
        offer(CDB_ALU, 4'd5, 32'h1234);
        cycle();
        idle();
        cycle();
        chk("t1_sgn",  64'(cdb_sgn),  64'd1);
        chk("t1_rob",  64'(cdb_rob),  64'd5);
        chk("t1_data", 64'(cdb_data), 64'h1234);
        chk("t1_src",  64'(cdb_src),  64'd0);
        cycle();
        chk("t1_sgn_off", 64'(cdb_sgn), 64'd0);

        // All sources push every cycle starting from rr=0.
        flush_cycle();
        seen.delete();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N_SRC; i++) offer(i, ROB_W'(c * 3 + i), $urandom);
            cycle();
        end
        idle();
        for (int c = 0; c < 8; c++) cycle();
        for (int j = 0; j < 6; j++) chk($sformatf("t2_order[%0d]", j), 64'(seen[j]), 64'(j % 3));

        // ALU back-to-back, no competitors.
        flush_cycle();
        for (int r = 1; r <= 3; r++) begin
            offer(CDB_ALU, ROB_W'(r), 32'(r * 16'h1111));
            cycle();
        end
        idle();
        for (int c = 0; c < 4; c++) cycle();

        // Fill, then flush with pushes still offered.
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N_SRC; i++) offer(i, ROB_W'($urandom), $urandom);
            cycle();
        end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        idle();
        chk("t4_sgn",   64'(cdb_sgn),   64'd0);
        #1;
        chk("t4_ready", 64'(src_ready), 64'd7);
        for (int c = 0; c < 3; c++) cycle();

        // Freeze with entries pending.
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < N_SRC; i++) offer(i, ROB_W'($urandom), $urandom);
            cycle();
        end
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) cycle();
        rdy = 1'b1;
        idle();
        for (int c = 0; c < 6; c++) cycle();

        // Load and ALU both backlogged.
        flush_cycle();
        seen.delete();
        for (int c = 0; c < 2; c++) begin
            offer(CDB_ALU, ROB_W'(c),     32'hA000 + 32'(c));
            offer(CDB_LD,  ROB_W'(c + 8), 32'hB000 + 32'(c));
            cycle();
        end
        idle();
        for (int c = 0; c < 5; c++) cycle();
        if (LOAD_PRIO) exp_t6 = '{1, 1, 0, 0};
        else           exp_t6 = '{0, 1, 0, 1};
        chk("t6_count", 64'(seen.size()), 64'd4);
        for (int j = 0; j < 4; j++)
            chk($sformatf("t6_order[%0d]", j), 64'(seen.size() > j ? seen[j] : -1), 64'(exp_t6[j]));

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N_SRC; i++) begin
                src_valid[i]                 = ($urandom_range(0, 99) < 60);
                src_rob[i*ROB_W +: ROB_W]    = ROB_W'($urandom);
                src_data[i*DATA_W +: DATA_W] = $urandom;
            end
            rdy   = ($urandom_range(0, 99) < 85);
            flush = ($urandom_range(0, 99) < 4);
            cycle();
        end
        flush = 1'b0; rdy = 1'b1;
        idle();
        for (int c = 0; c < 8; c++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
